pmod_acl2_spi_responder: RTL and testbench



---
 rtl/pmod_acl2_resp_pkg.sv | 52 +++++
 rtl/spi_resp_pin_sync.sv | 49 ++++
 rtl/pmod_acl2_spi_responder.sv | 223 ++++++++++++++++++++++
 tb/tb_pmod_acl2_spi_responder.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pmod_acl2_resp_pkg.sv
// Shared states, command codes and register addresses for the PMOD ACL2
// (ADXL362) SPI responder.
package pmod_acl2_resp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_WR,
        ST_RD,
        ST_IGNORE
    } t_resp_state;

    localparam logic [7:0] c_cmd_wr = 8'h0A;
    localparam logic [7:0] c_cmd_rd = 8'h0B;

    localparam logic [5:0] c_addr_devid_ad  = 6'h00;
    localparam logic [5:0] c_addr_devid_mst = 6'h01;
    localparam logic [5:0] c_addr_partid    = 6'h02;
    localparam logic [5:0] c_addr_revid     = 6'h03;
    localparam logic [5:0] c_addr_status    = 6'h0B;
    localparam logic [5:0] c_addr_xdata_l   = 6'h0E;
    localparam logic [5:0] c_addr_xdata_h   = 6'h0F;
    localparam logic [5:0] c_addr_ydata_l   = 6'h10;
    localparam logic [5:0] c_addr_ydata_h   = 6'h11;
    localparam logic [5:0] c_addr_zdata_l   = 6'h12;
    localparam logic [5:0] c_addr_zdata_h   = 6'h13;
    localparam logic [5:0] c_addr_temp_l    = 6'h14;
    localparam logic [5:0] c_addr_temp_h    = 6'h15;
    localparam logic [5:0] c_addr_soft_reset = 6'h1F;
    localparam logic [5:0] c_addr_intmap1   = 6'h2A;
    localparam logic [5:0] c_addr_intmap2   = 6'h2B;
    localparam logic [5:0] c_addr_power_ctl = 6'h2D;
    localparam logic [5:0] c_addr_wr_first  = 6'h1F;
    localparam logic [5:0] c_addr_wr_last   = 6'h2E;

    localparam logic [7:0] c_soft_reset_key = 8'h52;
    localparam logic [7:0] c_status_reset   = 8'h40;
    localparam logic [7:0] c_devid_mst      = 8'h1D;
    localparam logic [7:0] c_revid          = 8'h01;
    localparam int         c_num_wr_regs    = 16;

    function automatic logic is_writable(input logic [5:0] addr);
        return (addr >= c_addr_wr_first) && (addr <= c_addr_wr_last);
    endfunction

    // Index into the writable register file (0x1F maps to entry 0).
    function automatic logic [3:0] wr_index(input logic [5:0] addr);
        return 4'(addr - c_addr_wr_first);
    endfunction

endpackage

// File: rtl/spi_resp_pin_sync.sv
// Synchronizes the SCK/CSN/COPI pins into the system clock domain and
// produces single-cycle edge strobes from the last synchronizer stage.
module spi_resp_pin_sync #(
    parameter int parm_sync_stages = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic sck,
    input  logic csn,
    input  logic copi,
    output logic sck_rise,
    output logic sck_fall,
    output logic csn_fall,
    output logic csn_rise,
    output logic csn_level,
    output logic copi_sync
);

    logic [parm_sync_stages-1:0] sck_sr;
    logic [parm_sync_stages-1:0] csn_sr;
    logic [parm_sync_stages-1:0] copi_sr;
    logic                        sck_d;
    logic                        csn_d;

    // CSN idles high so reset never produces a spurious chip-select edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sck_sr  <= '0;
            csn_sr  <= '1;
            copi_sr <= '0;
            sck_d   <= 1'b0;
            csn_d   <= 1'b1;
        end else begin
            sck_sr  <= {sck_sr[parm_sync_stages-2:0], sck};
            csn_sr  <= {csn_sr[parm_sync_stages-2:0], csn};
            copi_sr <= {copi_sr[parm_sync_stages-2:0], copi};
            sck_d   <= sck_sr[parm_sync_stages-1];
            csn_d   <= csn_sr[parm_sync_stages-1];
        end
    end

    assign sck_rise  =  sck_sr[parm_sync_stages-1] & ~sck_d;
    assign sck_fall  = ~sck_sr[parm_sync_stages-1] &  sck_d;
    assign csn_fall  = ~csn_sr[parm_sync_stages-1] &  csn_d;
    assign csn_rise  =  csn_sr[parm_sync_stages-1] & ~csn_d;
    assign csn_level =  csn_sr[parm_sync_stages-1];
    assign copi_sync =  copi_sr[parm_sync_stages-1];

endmodule

// File: rtl/pmod_acl2_spi_responder.sv
// SPI mode-0 responder emulating the ADXL362 register protocol of the PMOD ACL2.
// Optional saturating protocol-error counter: define ACL2_RESP_ERR_COUNT_EN.
module pmod_acl2_spi_responder
    import pmod_acl2_resp_pkg::*;
#(
    parameter int         parm_sync_stages = 2,
    parameter logic [7:0] parm_devid_ad    = 8'hAD,
    parameter logic [7:0] parm_partid      = 8'hF2
) (
    input  logic        i_clk_20mhz,
    input  logic        i_rst_20mhz,
    input  logic        ei_sck,
    input  logic        ei_csn,
    input  logic        ei_copi,
    output logic        eo_cipo_o,
    output logic        eo_cipo_t,
    output logic        eo_int1,
    output logic        eo_int2,
    input  logic [63:0] i_data_3axis_temp,
    input  logic        i_data_load,
    input  logic        i_evt_act,
    input  logic        i_evt_inact,
    output logic [7:0]  o_reg_power_ctl,
    output logic        o_busy
`ifdef ACL2_RESP_ERR_COUNT_EN
    ,
    output logic [7:0]  o_err_count
`endif
);

    logic        sck_rise, sck_fall, csn_fall, csn_rise, csn_level, copi_sync;
    t_resp_state state, state_next;
    logic [2:0]  bit_cnt;
    logic [6:0]  shift_in;
    logic [7:0]  shift_out, rx_byte, rd_data;
    logic [5:0]  addr, rd_addr;
    logic        cmd_is_rd, byte_done, wr_en, soft_reset;
    logic [7:0]  wr_regs [c_num_wr_regs];
    logic [7:0]  data_regs [8];
    logic [7:0]  status, status_next;
    logic        load_pend, load_apply;
    logic [63:0] load_buf, load_src;

    spi_resp_pin_sync #(.parm_sync_stages(parm_sync_stages)) u_pin_sync (
        .clk       (i_clk_20mhz),
        .rst       (i_rst_20mhz),
        .sck       (ei_sck),
        .csn       (ei_csn),
        .copi      (ei_copi),
        .sck_rise  (sck_rise),
        .sck_fall  (sck_fall),
        .csn_fall  (csn_fall),
        .csn_rise  (csn_rise),
        .csn_level (csn_level),
        .copi_sync (copi_sync)
    );

    // Chip-select edges take priority over any SCK activity in the same cycle.
    assign rx_byte   = {shift_in, copi_sync};
    assign byte_done = sck_rise && (bit_cnt == 3'd7) && (state != ST_IDLE)
                       && !csn_rise && !csn_fall;
    assign wr_en      = byte_done && (state == ST_WR) && is_writable(addr);
    assign soft_reset = csn_rise && (wr_regs[wr_index(c_addr_soft_reset)] == c_soft_reset_key);
    assign load_apply = (i_data_load || load_pend) && (state != ST_RD);
    assign load_src   = (load_pend && !i_data_load) ? load_buf : i_data_3axis_temp;

    always_ff @(posedge i_clk_20mhz or posedge i_rst_20mhz) begin
        if (i_rst_20mhz) state <= ST_IDLE;
        else             state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (csn_rise) begin
            state_next = ST_IDLE;
        end else if (csn_fall) begin
            state_next = ST_CMD;
        end else if (byte_done) begin
            case (state)
                ST_CMD:  state_next = (rx_byte == c_cmd_wr || rx_byte == c_cmd_rd) ? ST_ADDR : ST_IGNORE;
                ST_ADDR: state_next = cmd_is_rd ? ST_RD : ST_WR;
                default: state_next = state;
            endcase
        end
    end

    // Address of the byte to preload: the freshly received address, or the next one in a burst.
    always_comb begin
        rd_addr = (state == ST_ADDR) ? rx_byte[5:0] : addr + 6'd1;
        rd_data = 8'h00;
        if (is_writable(rd_addr)) begin
            rd_data = wr_regs[wr_index(rd_addr)];
        end else if (rd_addr >= c_addr_xdata_l && rd_addr <= c_addr_temp_h) begin
            rd_data = data_regs[3'(rd_addr - c_addr_xdata_l)];
        end else begin
            case (rd_addr)
                c_addr_devid_ad:  rd_data = parm_devid_ad;
                c_addr_devid_mst: rd_data = c_devid_mst;
                c_addr_partid:    rd_data = parm_partid;
                c_addr_revid:     rd_data = c_revid;
                c_addr_status:    rd_data = status;
                default:          rd_data = 8'h00;
            endcase
        end
    end

    always_ff @(posedge i_clk_20mhz or posedge i_rst_20mhz) begin
        if (i_rst_20mhz) begin
            bit_cnt   <= 3'd0;
            shift_in  <= 7'd0;
            shift_out <= 8'h00;
            addr      <= 6'd0;
            cmd_is_rd <= 1'b0;
            eo_cipo_o <= 1'b0;
            eo_cipo_t <= 1'b1;
        end else if (csn_fall) begin
            bit_cnt   <= 3'd0;
            eo_cipo_o <= 1'b0;
            eo_cipo_t <= 1'b0;
        end else if (csn_rise) begin
            bit_cnt   <= 3'd0;
            eo_cipo_o <= 1'b0;
            eo_cipo_t <= 1'b1;
        end else if (state != ST_IDLE) begin
            if (sck_rise) begin
                shift_in <= rx_byte[6:0];
                bit_cnt  <= bit_cnt + 3'd1;
            end
            if (byte_done) begin
                case (state)
                    ST_CMD:  cmd_is_rd <= (rx_byte == c_cmd_rd);
                    ST_ADDR: begin
                        addr      <= rx_byte[5:0];
                        shift_out <= rd_data;
                    end
                    ST_WR:   addr <= addr + 6'd1;
                    ST_RD: begin
                        addr      <= addr + 6'd1;
                        shift_out <= rd_data;
                    end
                    default: ;
                endcase
            end
            if (sck_fall && state == ST_RD) begin
                eo_cipo_o <= shift_out[7];
                shift_out <= {shift_out[6:0], 1'b0};
            end
        end
    end

    always_comb begin
        status_next = status;
        if (byte_done && state == ST_RD && addr == c_addr_status) status_next[5:4] = 2'b00;
        if (byte_done && state == ST_RD && addr == c_addr_temp_h) status_next[0] = 1'b0;
        if (load_apply) status_next[0] = 1'b1;
        if (i_evt_inact) begin
            status_next[5] = 1'b1;
            status_next[6] = 1'b0;
        end else if (i_evt_act) begin
            status_next[4] = 1'b1;
            status_next[6] = 1'b1;
        end
    end

    // A load arriving mid-read is parked until the read transaction ends.
    always_ff @(posedge i_clk_20mhz or posedge i_rst_20mhz) begin
        if (i_rst_20mhz) begin
            load_pend <= 1'b0;
            load_buf  <= 64'd0;
        end else if (i_data_load && state == ST_RD) begin
            load_pend <= 1'b1;
            load_buf  <= i_data_3axis_temp;
        end else if (load_apply) begin
            load_pend <= 1'b0;
        end
    end

    always_ff @(posedge i_clk_20mhz or posedge i_rst_20mhz) begin
        if (i_rst_20mhz) begin
            for (int i = 0; i < c_num_wr_regs; i++) wr_regs[i] <= 8'h00;
            for (int i = 0; i < 8; i++) data_regs[i] <= 8'h00;
            status <= c_status_reset;
        end else if (soft_reset) begin
            for (int i = 0; i < c_num_wr_regs; i++) wr_regs[i] <= 8'h00;
            for (int i = 0; i < 8; i++) data_regs[i] <= 8'h00;
            status <= c_status_reset;
        end else begin
            if (wr_en) wr_regs[wr_index(addr)] <= rx_byte;
            if (load_apply) begin
                for (int i = 0; i < 8; i++) data_regs[i] <= load_src[8*i +: 8];
            end
            status <= status_next;
        end
    end

    always_ff @(posedge i_clk_20mhz or posedge i_rst_20mhz) begin
        if (i_rst_20mhz) begin
            eo_int1 <= 1'b0;
            eo_int2 <= 1'b0;
        end else begin
            eo_int1 <= (|(status[6:0] & wr_regs[wr_index(c_addr_intmap1)][6:0]))
                       ^ wr_regs[wr_index(c_addr_intmap1)][7];
            eo_int2 <= (|(status[6:0] & wr_regs[wr_index(c_addr_intmap2)][6:0]))
                       ^ wr_regs[wr_index(c_addr_intmap2)][7];
        end
    end

    assign o_reg_power_ctl = wr_regs[wr_index(c_addr_power_ctl)];
    assign o_busy          = ~csn_level;

`ifdef ACL2_RESP_ERR_COUNT_EN
    logic err_inc;

    assign err_inc = (byte_done && state == ST_CMD && rx_byte != c_cmd_wr && rx_byte != c_cmd_rd)
                     || (csn_rise && state != ST_IDLE && bit_cnt != 3'd0);

    always_ff @(posedge i_clk_20mhz or posedge i_rst_20mhz) begin
        if (i_rst_20mhz)                        o_err_count <= 8'd0;
        else if (err_inc && o_err_count != 8'hFF) o_err_count <= o_err_count + 8'd1;
    end
`endif

endmodule

// File: tb/tb_pmod_acl2_spi_responder.sv
// Directed bench for the ACL2 SPI responder: mode-0 controller tasks driving
// SCK at FCLK/10 and immediate-assertion checks against hand-computed values.
`timescale 1ns/1ps
module tb_pmod_acl2_spi_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sck = 1'b0;
    logic        csn = 1'b1;
    logic        copi = 1'b0;
    logic [63:0] data = 64'd0;
    logic        data_load = 1'b0;
    logic        evt_act = 1'b0;
    logic        evt_inact = 1'b0;
    logic        cipo_o, cipo_t, int1, int2, busy;
    logic [7:0]  power_ctl;
`ifdef ACL2_RESP_ERR_COUNT_EN
    logic [7:0]  err_count;
`endif

    int          total = 0;
    int          bad = 0;
    logic [7:0]  rx;

    always #25 clk = ~clk;

    pmod_acl2_spi_responder dut (
        .i_clk_20mhz       (clk),
        .i_rst_20mhz       (rst),
        .ei_sck            (sck),
        .ei_csn            (csn),
        .ei_copi           (copi),
        .eo_cipo_o         (cipo_o),
        .eo_cipo_t         (cipo_t),
        .eo_int1           (int1),
        .eo_int2           (int2),
        .i_data_3axis_temp (data),
        .i_data_load       (data_load),
        .i_evt_act         (evt_act),
        .i_evt_inact       (evt_inact),
        .o_reg_power_ctl   (power_ctl),
        .o_busy            (busy)
`ifdef ACL2_RESP_ERR_COUNT_EN
        ,
        .o_err_count       (err_count)
`endif
    );

    task automatic half();
        repeat (5) @(negedge clk);
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic cs_low();
        csn = 1'b0;
        half();
    endtask

    task automatic cs_high();
        sck = 1'b0;
        half();
        csn = 1'b1;
        half();
        half();
    endtask

    task automatic xfer_bits(input logic [7:0] tx, input int n, output logic [7:0] got);
        got = 8'h00;
        for (int i = 0; i < n; i++) begin
            copi = tx[7-i];
            half();
            got[7-i] = cipo_o;
            sck = 1'b1;
            half();
            sck = 1'b0;
        end
    endtask

    task automatic xfer(input logic [7:0] tx, output logic [7:0] got);
        xfer_bits(tx, 8, got);
    endtask

    task automatic wr_reg(input logic [7:0] a, input logic [7:0] d);
        logic [7:0] dummy;
        cs_low();
        xfer(8'h0A, dummy);
        xfer(a, dummy);
        xfer(d, dummy);
        cs_high();
    endtask

    task automatic rd_reg(input logic [7:0] a, output logic [7:0] d);
        logic [7:0] dummy;
        cs_low();
        xfer(8'h0B, dummy);
        xfer(a, dummy);
        xfer(8'h00, d);
        cs_high();
    endtask

    task automatic pulse_evt(input logic act, input logic inact);
        @(negedge clk);
        evt_act = act;
        evt_inact = inact;
        @(negedge clk);
        evt_act = 1'b0;
        evt_inact = 1'b0;
    endtask

    initial begin
        logic [7:0] exp_id [4];
        exp_id[0] = 8'hAD; exp_id[1] = 8'h1D; exp_id[2] = 8'hF2; exp_id[3] = 8'h01;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk1("rst_cipo_t", cipo_t, 1'b1);
        chk1("rst_cipo_o", cipo_o, 1'b0);
        chk1("rst_int1", int1, 1'b0);
        chk1("rst_int2", int2, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk8("rst_power_ctl", power_ctl, 8'h00);
`ifdef ACL2_RESP_ERR_COUNT_EN
        chk8("rst_err_count", err_count, 8'h00);
`endif

        // ID registers, burst read from 0x00
        cs_low();
        chk1("cs_busy", busy, 1'b1);
        chk1("cs_cipo_t", cipo_t, 1'b0);
        xfer(8'h0B, rx);
        xfer(8'h00, rx);
        for (int i = 0; i < 4; i++) begin
            xfer(8'h00, rx);
            chk8("id_burst", rx, exp_id[i]);
        end
        cs_high();
        chk1("idle_cipo_t", cipo_t, 1'b1);
        rd_reg(8'h0B, rx);
        chk8("status_reset", rx, 8'h40);

        // Interrupt map and activity/inactivity status
        wr_reg(8'h2A, 8'h10);
        rd_reg(8'h2A, rx);
        chk8("intmap1_rd", rx, 8'h10);
        chk1("int1_before_act", int1, 1'b0);
        pulse_evt(1'b1, 1'b0);
        @(negedge clk);
        chk1("int1_after_act", int1, 1'b1);
        chk1("int2_after_act", int2, 1'b0);
        rd_reg(8'h0B, rx);
        chk8("status_act", rx, 8'h50);
        chk1("int1_after_rd", int1, 1'b0);
        rd_reg(8'h0B, rx);
        chk8("status_act_cleared", rx, 8'h40);
        pulse_evt(1'b0, 1'b1);
        rd_reg(8'h0B, rx);
        chk8("status_inact", rx, 8'h20);
        pulse_evt(1'b1, 1'b1);
        rd_reg(8'h0B, rx);
        chk8("status_both_inact_wins", rx, 8'h20);
        pulse_evt(1'b1, 1'b0);
        rd_reg(8'h0B, rx);
        chk8("status_act_again", rx, 8'h50);

        // Measurement load and burst read of 0x0E..0x15
        data = 64'h0807060504030201;
        @(negedge clk);
        data_load = 1'b1;
        @(negedge clk);
        data_load = 1'b0;
        rd_reg(8'h0B, rx);
        chk8("status_data_ready", rx, 8'h41);
        cs_low();
        xfer(8'h0B, rx);
        xfer(8'h0E, rx);
        for (int i = 0; i < 8; i++) begin
            logic [7:0] e;
            e = 8'(i + 1);
            xfer(8'h00, rx);
            chk8("data_burst", rx, e);
        end
        cs_high();
        rd_reg(8'h0B, rx);
        chk8("status_dr_cleared", rx, 8'h40);

        // Load during a read is held back until CSN rises
        cs_low();
        xfer(8'h0B, rx);
        xfer(8'h0E, rx);
        xfer(8'h00, rx);
        chk8("coherent_b0", rx, 8'h01);
        data = 64'hA8A7A6A5A4A3A2A1;
        data_load = 1'b1;
        @(negedge clk);
        data_load = 1'b0;
        xfer(8'h00, rx);
        chk8("coherent_b1", rx, 8'h02);
        cs_high();
        rd_reg(8'h0E, rx);
        chk8("deferred_load", rx, 8'hA1);

        // Writable range boundary and address wrap
        wr_reg(8'h2D, 8'h03);
        chk8("power_ctl_wr", power_ctl, 8'h03);
        cs_low();
        xfer(8'h0A, rx);
        xfer(8'h2E, rx);
        xfer(8'h5A, rx);
        xfer(8'h77, rx);
        cs_high();
        rd_reg(8'h2E, rx);
        chk8("reg_2e", rx, 8'h5A);
        rd_reg(8'h2F, rx);
        chk8("reg_2f_dropped", rx, 8'h00);
        chk8("power_ctl_kept", power_ctl, 8'h03);
        cs_low();
        xfer(8'h0B, rx);
        xfer(8'h3F, rx);
        xfer(8'h00, rx);
        chk8("unmapped_3f", rx, 8'h00);
        xfer(8'h00, rx);
        chk8("wrap_to_00", rx, 8'hAD);
        cs_high();

        // Partial byte is discarded; unknown command returns zeros
        cs_low();
        xfer(8'h0A, rx);
        xfer(8'h2E, rx);
        xfer_bits(8'hFF, 5, rx);
        cs_high();
        rd_reg(8'h2E, rx);
        chk8("partial_discarded", rx, 8'h5A);
`ifdef ACL2_RESP_ERR_COUNT_EN
        chk8("err_partial", err_count, 8'd1);
`endif
        cs_low();
        xfer(8'h0D, rx);
        xfer(8'hFF, rx);
        chk8("ignore_b0", rx, 8'h00);
        xfer(8'hFF, rx);
        chk8("ignore_b1", rx, 8'h00);
        cs_high();
`ifdef ACL2_RESP_ERR_COUNT_EN
        chk8("err_bad_cmd", err_count, 8'd2);
`endif

        // Interrupt polarity inversion, then soft reset
        cs_low();
        xfer(8'h0A, rx);
        xfer(8'h2A, rx);
        xfer(8'h80, rx);
        xfer(8'h40, rx);
        cs_high();
        chk1("int1_inverted", int1, 1'b1);
        chk1("int2_awake", int2, 1'b1);
        wr_reg(8'h1F, 8'h52);
        chk1("int1_soft_rst", int1, 1'b0);
        chk1("int2_soft_rst", int2, 1'b0);
        chk8("power_ctl_soft_rst", power_ctl, 8'h00);
        rd_reg(8'h2A, rx);
        chk8("intmap1_soft_rst", rx, 8'h00);
        rd_reg(8'h0B, rx);
        chk8("status_soft_rst", rx, 8'h40);
        rd_reg(8'h0E, rx);
        chk8("data_soft_rst", rx, 8'h00);
        rd_reg(8'h1F, rx);
        chk8("soft_rst_reg", rx, 8'h00);

        // Asynchronous reset in the middle of a read
        cs_low();
        xfer(8'h0B, rx);
        xfer(8'h00, rx);
        xfer_bits(8'h00, 3, rx);
        chk1("mid_read_cipo_t", cipo_t, 1'b0);
        #5 rst = 1'b1;
        #1;
        chk1("async_rst_cipo_t", cipo_t, 1'b1);
        chk1("async_rst_busy", busy, 1'b0);
        csn = 1'b1;
        sck = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        rd_reg(8'h00, rx);
        chk8("after_async_rst", rx, 8'hAD);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
